// File: rtl/dcache_pkg.sv
// Shared types and width constants for the direct-mapped data cache.
// The optional statistics counters are enabled with DCACHE_STATS_EN.
package dcache_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 32;
   localparam int SET_BITS_DEF = 6;
   localparam int OFFSET_BITS  = 2;
   localparam int INDEX_BITS_DEF = SET_BITS_DEF;
   localparam int TAG_BITS_DEF = ADDR_W_DEF - SET_BITS_DEF - OFFSET_BITS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } dc_state_t;

   function automatic int tag_bits(input int addr_w, input int set_bits);
      return addr_w - set_bits - OFFSET_BITS;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one write port, combinational read at the same index.
// Valid bits clear on reset; tag and data contents are qualified by valid.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int SET_BITS = SET_BITS_DEF,
   parameter int TAG_W    = TAG_BITS_DEF,
   parameter int DATA_W   = DATA_W_DEF
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_we,
   input  logic [SET_BITS-1:0] i_index,
   input  logic [TAG_W-1:0]    i_tag,
   input  logic [DATA_W-1:0]   i_data,
   output logic                o_valid,
   output logic [TAG_W-1:0]    o_tag,
   output logic [DATA_W-1:0]   o_data
);

   localparam int LINES = 1 << SET_BITS;

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [DATA_W-1:0] r_data [LINES];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_index]  <= i_tag;
         r_data[i_index] <= i_data;
      end
   end

   assign o_valid = r_valid[i_index];
   assign o_tag   = r_tag[i_index];
   assign o_data  = r_data[i_index];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Defining DCACHE_STATS_EN adds wrapping hit/miss counters as outputs.
module data_cache_ctrl
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W_DEF,
   parameter int ADDR_WIDTH = ADDR_W_DEF,
   parameter int SET_BITS   = SET_BITS_DEF
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemRead_i,
   input  logic                  MemWrite_i,
   input  logic [ADDR_WIDTH-1:0] ALUResult_i,
   input  logic [DATA_WIDTH-1:0] WriteData_i,
   output logic [DATA_WIDTH-1:0] ReadData_o,
   output logic                  cache_miss_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
`ifdef DCACHE_STATS_EN
   output logic [31:0]           hit_count_o,
   output logic [31:0]           miss_count_o,
`endif
   output dc_state_t             dbg_state_o
);

   localparam int TAG_W = tag_bits(ADDR_WIDTH, SET_BITS);

   dc_state_t             r_state;
   dc_state_t             w_next_state;
   logic [SET_BITS-1:0]   w_index;
   logic [TAG_W-1:0]      w_tag;
   logic                  w_line_valid;
   logic [TAG_W-1:0]      w_line_tag;
   logic [DATA_WIDTH-1:0] w_line_data;
   logic                  w_hit;
   logic                  w_load;
   logic                  w_store;
   logic                  w_arr_we;
   logic [DATA_WIDTH-1:0] w_arr_data;
   logic [ADDR_WIDTH-1:0] w_word_addr;
   logic [1:0]            w_unused_offset;

   assign w_index         = ALUResult_i[SET_BITS+OFFSET_BITS-1:OFFSET_BITS];
   assign w_tag           = ALUResult_i[ADDR_WIDTH-1:SET_BITS+OFFSET_BITS];
   assign w_word_addr     = {ALUResult_i[ADDR_WIDTH-1:OFFSET_BITS], 2'b00};
   assign w_unused_offset = ALUResult_i[1:0];
   assign w_store         = MemWrite_i;
   assign w_load          = MemRead_i & ~MemWrite_i;
   assign w_hit           = w_line_valid && (w_line_tag == w_tag);

   // Fills always allocate; store acks only refresh a line already holding this tag.
   // Gating with rst_n drops an ack that coincides with a reset edge.
   assign w_arr_we   = rst_n && mem_ack_i &&
                       ((r_state == ST_FILL) || ((r_state == ST_WRITE) && w_hit));
   assign w_arr_data = (r_state == ST_FILL) ? mem_rdata_i : WriteData_i;

   dcache_array #(
      .SET_BITS (SET_BITS),
      .TAG_W    (TAG_W),
      .DATA_W   (DATA_WIDTH)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_arr_we),
      .i_index (w_index),
      .i_tag   (w_tag),
      .i_data  (w_arr_data),
      .o_valid (w_line_valid),
      .o_tag   (w_line_tag),
      .o_data  (w_line_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_store) begin
               w_next_state = ST_WRITE;
            end else if (w_load && !w_hit) begin
               w_next_state = ST_FILL;
            end
         end
         ST_FILL:  if (mem_ack_i) w_next_state = ST_IDLE;
         ST_WRITE: if (mem_ack_i) w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Memory request lines depend on r_state only, never on mem_ack_i.
   always_comb begin
      ReadData_o   = '0;
      cache_miss_o = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      case (r_state)
         ST_IDLE: begin
            cache_miss_o = w_store || (w_load && !w_hit);
            if (w_load && w_hit) begin
               ReadData_o = w_line_data;
            end
         end
         ST_FILL: begin
            cache_miss_o = 1'b1;
            mem_req_o    = 1'b1;
            mem_addr_o   = w_word_addr;
         end
         ST_WRITE: begin
            cache_miss_o = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = 1'b1;
            mem_addr_o   = w_word_addr;
            mem_wdata_o  = WriteData_i;
         end
         default: ;
      endcase
   end

   assign dbg_state_o = r_state;

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic        r_after_fill;

   // The replay that follows a fill completes the original miss and is not a new hit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
         r_after_fill <= 1'b0;
      end else begin
         r_after_fill <= (r_state == ST_FILL) && mem_ack_i;
         if ((r_state == ST_IDLE) && w_load && w_hit && !r_after_fill) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if ((r_state == ST_IDLE) && (w_next_state == ST_FILL)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_count_o  = r_hit_cnt;
   assign miss_count_o = r_miss_cnt;
`endif

endmodule
